dcache_coherent: RTL and testbench

DCACHE_COHERENT -- requirements
Module: dcache_coherent

---
 rtl/dcache_coherent_if.sv | 41 ++++
 rtl/dcache_coherent.sv | 221 ++++++++++++++++++++++
 tb/tb_dcache_coherent.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_coherent_if.sv
// Bundle of processor-side, memory-side and coherence signals for one cache.
interface dcache_coherent_if;
    // Processor side
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic [31:0] dmemload;
    logic        dhit;
    // Memory controller side
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        cctrans;
    logic        ccwrite;
    logic [31:0] dload;
    logic        dwait;
    // Coherence snoop side
    logic        ccwait;
    logic        ccinv;
    logic [31:0] ccsnoopaddr;

    // Cache end of the bundle
    modport slave (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore,
        output dmemload, dhit,
        output dREN, dWEN, daddr, dstore, cctrans, ccwrite,
        input  dload, dwait,
        input  ccwait, ccinv, ccsnoopaddr
    );

    // Processor / memory controller end of the bundle
    modport master (
        output dmemREN, dmemWEN, dmemaddr, dmemstore,
        input  dmemload, dhit,
        input  dREN, dWEN, daddr, dstore, cctrans, ccwrite,
        output dload, dwait,
        output ccwait, ccinv, ccsnoopaddr
    );
endinterface

// File: rtl/dcache_coherent.sv
// Direct-mapped one-word-per-frame write-back data cache with MSI snooping.
module dcache_coherent #(
    parameter int unsigned SETS  = 16,
    parameter int unsigned CPUID = 0
) (
    input  logic              CLK,
    input  logic              nRST,
    dcache_coherent_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = 32 - 2 - IDX_W;

    typedef enum logic [1:0] {ST_I = 2'd0, ST_S = 2'd1, ST_M = 2'd2} msi_e;
    typedef enum logic [1:0] {M_IDLE = 2'd0, M_WB = 2'd1, M_FETCH = 2'd2, M_DONE = 2'd3} main_e;
    typedef enum logic [1:0] {SN_IDLE = 2'd0, SN_WB = 2'd1, SN_DONE = 2'd2} snoop_e;

    // Frame storage
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [31:0]      data_q [SETS];
    msi_e             st_q   [SETS];

    main_e  main_q, main_d;
    snoop_e sn_q, sn_d;
    msi_e   cap_q, cap_d;    // victim state observed when the miss was launched

    logic [IDX_W-1:0] req_idx, sn_idx;
    logic [TAG_W-1:0] req_tag, sn_tag;
    msi_e             cur_st, sn_st;
    logic             req_c, tag_hit_c, hit_c, abort_c, sn_match_c;

    logic             m_upd_c, m_inv_c, s_set_c;
    msi_e             s_st_c;

    logic             dren_c, dwen_c, cctrans_c, ccwrite_c;
    logic [31:0]      daddr_c, dstore_c;

    logic             unused_c;
    assign unused_c = ^32'(CPUID);

    // Address decode and frame lookup for the processor and snoop ports
    assign req_idx    = bus.dmemaddr[2 +: IDX_W];
    assign req_tag    = bus.dmemaddr[31 -: TAG_W];
    assign sn_idx     = bus.ccsnoopaddr[2 +: IDX_W];
    assign sn_tag     = bus.ccsnoopaddr[31 -: TAG_W];
    assign cur_st     = st_q[req_idx];
    assign sn_st      = st_q[sn_idx];
    assign tag_hit_c  = (tag_q[req_idx] == req_tag);
    assign sn_match_c = (sn_st != ST_I) && (tag_q[sn_idx] == sn_tag);
    assign req_c      = bus.dmemREN | bus.dmemWEN;

    // Hit only when the main FSM is not on the bus and no snoop is active
    assign hit_c = ((main_q == M_IDLE) || (main_q == M_DONE)) && !bus.ccwait && tag_hit_c &&
                   (bus.dmemWEN ? (cur_st == ST_M) : (bus.dmemREN && (cur_st != ST_I)));

    // A snoop changed the frame under an outstanding miss
    assign abort_c = (cur_st != cap_q);

    // Main and snoop FSM state registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            main_q <= M_IDLE;
            sn_q   <= SN_IDLE;
            cap_q  <= ST_I;
        end else begin
            main_q <= main_d;
            sn_q   <= sn_d;
            cap_q  <= cap_d;
        end
    end

    // Main FSM next state; frozen while a snoop owns the bus
    always_comb begin
        main_d = main_q;
        cap_d  = cap_q;
        if (!bus.ccwait) begin
            case (main_q)
                M_IDLE: begin
                    if (req_c && !hit_c) begin
                        cap_d  = cur_st;
                        main_d = (cur_st == ST_M) ? M_WB : M_FETCH;
                    end
                end
                M_WB: begin
                    if (abort_c) begin
                        main_d = M_IDLE;
                    end else if (!bus.dwait) begin
                        main_d = M_FETCH;
                        cap_d  = ST_I;
                    end
                end
                M_FETCH: begin
                    if (abort_c) begin
                        main_d = M_IDLE;
                    end else if (!bus.dwait) begin
                        main_d = M_DONE;
                    end
                end
                default: main_d = M_IDLE;
            endcase
        end
    end

    // Snoop FSM next state
    always_comb begin
        sn_d = sn_q;
        case (sn_q)
            SN_IDLE: begin
                if (bus.ccwait) begin
                    sn_d = (sn_match_c && (sn_st == ST_M)) ? SN_WB : SN_DONE;
                end
            end
            SN_WB: begin
                if (!bus.dwait) begin
                    sn_d = SN_DONE;
                end
            end
            SN_DONE: begin
                if (!bus.ccwait) begin
                    sn_d = SN_IDLE;
                end
            end
            default: sn_d = SN_IDLE;
        endcase
    end

    // Snoop outputs: frame state changes on invalidate or completed writeback
    always_comb begin
        s_set_c = 1'b0;
        s_st_c  = ST_I;
        case (sn_q)
            SN_IDLE: begin
                if (bus.ccwait && bus.ccinv && sn_match_c && (sn_st == ST_S)) begin
                    s_set_c = 1'b1;
                    s_st_c  = ST_I;
                end
            end
            SN_WB: begin
                if (!bus.dwait) begin
                    s_set_c = 1'b1;
                    s_st_c  = bus.ccinv ? ST_I : ST_S;
                end
            end
            default: ;
        endcase
    end

    // Main outputs and bus mux; a snoop overrides every main request
    always_comb begin
        dren_c    = 1'b0;
        dwen_c    = 1'b0;
        cctrans_c = 1'b0;
        ccwrite_c = 1'b0;
        daddr_c   = 32'd0;
        dstore_c  = 32'd0;
        m_upd_c   = 1'b0;
        m_inv_c   = 1'b0;
        if (bus.ccwait) begin
            if (sn_q == SN_WB) begin
                dwen_c   = 1'b1;
                daddr_c  = bus.ccsnoopaddr;
                dstore_c = data_q[sn_idx];
            end
        end else begin
            case (main_q)
                M_WB: begin
                    if (!abort_c) begin
                        dwen_c   = 1'b1;
                        daddr_c  = {tag_q[req_idx], req_idx, 2'b00};
                        dstore_c = data_q[req_idx];
                        m_inv_c  = !bus.dwait;
                    end
                end
                M_FETCH: begin
                    if (!abort_c) begin
                        dren_c    = 1'b1;
                        cctrans_c = 1'b1;
                        ccwrite_c = bus.dmemWEN;
                        daddr_c   = bus.dmemaddr;
                        m_upd_c   = !bus.dwait;
                    end
                end
                default: ;
            endcase
            if (hit_c && bus.dmemWEN) begin
                m_upd_c = 1'b1;
            end
        end
    end

    assign bus.dREN     = dren_c;
    assign bus.dWEN     = dwen_c;
    assign bus.cctrans  = cctrans_c;
    assign bus.ccwrite  = ccwrite_c;
    assign bus.daddr    = daddr_c;
    assign bus.dstore   = dstore_c;
    assign bus.dhit     = hit_c;
    assign bus.dmemload = hit_c ? data_q[req_idx] : 32'd0;

    // Frame array update; snoop state change applied last
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < int'(SETS); i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= 32'd0;
                st_q[i]   <= ST_I;
            end
        end else begin
            if (m_upd_c) begin
                tag_q[req_idx]  <= req_tag;
                data_q[req_idx] <= bus.dmemWEN ? bus.dmemstore : bus.dload;
                st_q[req_idx]   <= bus.dmemWEN ? ST_M : ST_S;
            end
            if (m_inv_c) begin
                st_q[req_idx] <= ST_I;
            end
            if (s_set_c) begin
                st_q[sn_idx] <= s_st_c;
            end
        end
    end
endmodule

// File: tb/tb_dcache_coherent.sv
// Directed bench for dcache_coherent: fills, evictions, snoops, aborts, reset.
module tb_dcache_coherent;
    logic CLK = 1'b0;
    logic nRST;

    always #5 CLK = ~CLK;

    dcache_coherent_if bus ();

    dcache_coherent #(.SETS(16), .CPUID(0)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic req(input logic ren, input logic wen, input logic [31:0] addr, input logic [31:0] st);
        bus.dmemREN   = ren;
        bus.dmemWEN   = wen;
        bus.dmemaddr  = addr;
        bus.dmemstore = st;
    endtask

    task automatic mem(input logic wt, input logic [31:0] ld);
        bus.dwait = wt;
        bus.dload = ld;
    endtask

    task automatic snp(input logic w, input logic inv, input logic [31:0] addr);
        bus.ccwait      = w;
        bus.ccinv       = inv;
        bus.ccsnoopaddr = addr;
    endtask

    initial begin
        req(0, 0, 32'h0, 32'h0);
        mem(1, 32'h0);
        snp(0, 0, 32'h0);
        nRST = 1'b0;

        // Reset: all outputs quiet even with a request pending
        #2;
        req(1, 0, 32'h0, 32'h0);
        settle;
        check("rst_dhit",    32'(bus.dhit), 32'd0);
        check("rst_dren",    32'(bus.dREN), 32'd0);
        check("rst_dwen",    32'(bus.dWEN), 32'd0);
        check("rst_cctrans", 32'(bus.cctrans), 32'd0);
        req(0, 0, 32'h0, 32'h0);
        tick; tick;
        nRST = 1'b1;

        // Cold read 0x40, dwait low on third FETCH cycle
        tick; req(1, 0, 32'h40, 32'h0); settle;
        check("a_idle_dhit", 32'(bus.dhit), 32'd0);
        check("a_idle_dren", 32'(bus.dREN), 32'd0);
        tick; settle;
        check("a_fetch_dren",    32'(bus.dREN), 32'd1);
        check("a_fetch_cctrans", 32'(bus.cctrans), 32'd1);
        check("a_fetch_ccwrite", 32'(bus.ccwrite), 32'd0);
        check("a_fetch_daddr",   bus.daddr, 32'h40);
        tick;
        tick; mem(0, 32'hDEAD); settle;
        check("a_fetch3_dren", 32'(bus.dREN), 32'd1);
        tick; mem(1, 32'h0); settle;
        check("a_done_dhit", 32'(bus.dhit), 32'd1);
        check("a_done_load", bus.dmemload, 32'hDEAD);
        check("a_done_dren", 32'(bus.dREN), 32'd0);
        tick; req(1, 0, 32'h40, 32'h0); settle;
        check("a_rehit_dhit", 32'(bus.dhit), 32'd1);
        check("a_rehit_load", bus.dmemload, 32'hDEAD);

        // Write miss to 0x0 over a clean frame: straight to FETCH
        tick; req(0, 1, 32'h0, 32'h11); settle;
        check("b_miss_dhit", 32'(bus.dhit), 32'd0);
        tick; mem(0, 32'hBEEF); settle;
        check("b_fetch_dren",    32'(bus.dREN), 32'd1);
        check("b_fetch_ccwrite", 32'(bus.ccwrite), 32'd1);
        check("b_fetch_daddr",   bus.daddr, 32'h0);
        check("b_fetch_dwen",    32'(bus.dWEN), 32'd0);
        tick; mem(1, 32'h0); settle;
        check("b_done_dhit", 32'(bus.dhit), 32'd1);
        tick; req(1, 0, 32'h0, 32'h0); settle;
        check("b_rd_dhit", 32'(bus.dhit), 32'd1);
        check("b_rd_load", bus.dmemload, 32'h11);

        // Dirty eviction: write 0x400 over M frame 0 holding 0x0
        tick; req(0, 1, 32'h400, 32'h22); settle;
        check("c_miss_dhit", 32'(bus.dhit), 32'd0);
        tick; settle;
        check("c_wb_dwen",    32'(bus.dWEN), 32'd1);
        check("c_wb_dren",    32'(bus.dREN), 32'd0);
        check("c_wb_cctrans", 32'(bus.cctrans), 32'd0);
        check("c_wb_daddr",   bus.daddr, 32'h0);
        check("c_wb_dstore",  bus.dstore, 32'h11);
        tick; mem(0, 32'h0); settle;
        check("c_wb2_dwen", 32'(bus.dWEN), 32'd1);
        tick; mem(0, 32'h0); settle;
        check("c_fetch_dren",    32'(bus.dREN), 32'd1);
        check("c_fetch_ccwrite", 32'(bus.ccwrite), 32'd1);
        check("c_fetch_daddr",   bus.daddr, 32'h400);
        check("c_fetch_dwen",    32'(bus.dWEN), 32'd0);
        tick; mem(1, 32'h0); settle;
        check("c_done_dhit", 32'(bus.dhit), 32'd1);
        tick; req(1, 0, 32'h400, 32'h0); settle;
        check("c_rd_dhit", 32'(bus.dhit), 32'd1);
        check("c_rd_load", bus.dmemload, 32'h22);
        req(1, 0, 32'h0, 32'h0); settle;
        check("c_old_miss", 32'(bus.dhit), 32'd0);
        req(0, 0, 32'h0, 32'h0);

        // Make 0x80 modified with 0x55 (evicts 0x400), then snoop-read it
        tick; req(0, 1, 32'h80, 32'h55); settle;
        tick; mem(0, 32'h0); settle;
        check("d_wb_daddr",  bus.daddr, 32'h400);
        check("d_wb_dstore", bus.dstore, 32'h22);
        tick; mem(0, 32'h0); settle;
        check("d_fetch_daddr", bus.daddr, 32'h80);
        tick; mem(1, 32'h0); settle;
        check("d_done_dhit", 32'(bus.dhit), 32'd1);
        tick; req(0, 0, 32'h0, 32'h0); snp(1, 0, 32'h80); settle;
        check("d_sn0_dwen", 32'(bus.dWEN), 32'd0);
        tick; settle;
        check("d_snwb_dwen",   32'(bus.dWEN), 32'd1);
        check("d_snwb_daddr",  bus.daddr, 32'h80);
        check("d_snwb_dstore", bus.dstore, 32'h55);
        check("d_snwb_dren",   32'(bus.dREN), 32'd0);
        tick; mem(0, 32'h0); settle;
        tick; mem(1, 32'h0); req(1, 0, 32'h80, 32'h0); settle;
        check("d_sndone_dwen",   32'(bus.dWEN), 32'd0);
        check("d_ccwait_nohit", 32'(bus.dhit), 32'd0);
        tick; snp(0, 0, 32'h0); settle;
        check("d_rd_dhit", 32'(bus.dhit), 32'd1);
        check("d_rd_load", bus.dmemload, 32'h55);
        req(1, 1, 32'h80, 32'h66); settle;
        check("d_wr_s_dhit", 32'(bus.dhit), 32'd0);
        tick; mem(0, 32'h0); settle;
        check("d_up_ccwrite", 32'(bus.ccwrite), 32'd1);
        check("d_up_dren",    32'(bus.dREN), 32'd1);
        check("d_up_daddr",   bus.daddr, 32'h80);
        tick; mem(1, 32'h0); settle;
        check("d_up_dhit", 32'(bus.dhit), 32'd1);
        tick; req(0, 0, 32'h0, 32'h0);

        // Downgrade 0x80 to S by snoop, then invalidate it with no bus write
        snp(1, 0, 32'h80); settle;
        tick; mem(0, 32'h0); settle;
        check("e_snwb_dstore", bus.dstore, 32'h66);
        tick; mem(1, 32'h0); snp(0, 0, 32'h0); settle;
        tick; snp(1, 1, 32'h80); settle;
        check("e_inv0_dwen", 32'(bus.dWEN), 32'd0);
        tick; settle;
        check("e_inv1_dwen", 32'(bus.dWEN), 32'd0);
        snp(0, 0, 32'h0);
        tick; req(1, 0, 32'h80, 32'h0); settle;
        check("e_miss_dhit", 32'(bus.dhit), 32'd0);
        req(0, 0, 32'h0, 32'h0);

        // Snoop arrives mid-FETCH of 0x44
        tick; req(1, 0, 32'h44, 32'h0); settle;
        tick; settle;
        check("f_dren",  32'(bus.dREN), 32'd1);
        check("f_daddr", bus.daddr, 32'h44);
        tick; snp(1, 0, 32'h84); settle;
        check("f_sn_dren",    32'(bus.dREN), 32'd0);
        check("f_sn_cctrans", 32'(bus.cctrans), 32'd0);
        tick; settle;
        check("f_sn2_dren", 32'(bus.dREN), 32'd0);
        check("f_sn2_dwen", 32'(bus.dWEN), 32'd0);
        tick; snp(0, 0, 32'h0); settle;
        check("f_re_dren",    32'(bus.dREN), 32'd1);
        check("f_re_daddr",   bus.daddr, 32'h44);
        check("f_re_cctrans", 32'(bus.cctrans), 32'd1);
        tick; mem(0, 32'h99); settle;
        tick; mem(1, 32'h0); settle;
        check("f_done_dhit", 32'(bus.dhit), 32'd1);
        check("f_done_load", bus.dmemload, 32'h99);
        tick; req(0, 0, 32'h0, 32'h0);

        // Snoop invalidates the victim during WB: main aborts and refetches
        tick; req(0, 1, 32'h4, 32'hAB); settle;
        tick; mem(0, 32'h0); settle;
        tick; mem(1, 32'h0); settle;
        check("g_w4_dhit", 32'(bus.dhit), 32'd1);
        tick; req(0, 1, 32'h44, 32'hCD); settle;
        tick; snp(1, 1, 32'h4); settle;
        check("g_hold_dwen", 32'(bus.dWEN), 32'd0);
        tick; mem(0, 32'h0); settle;
        check("g_snwb_dwen",   32'(bus.dWEN), 32'd1);
        check("g_snwb_daddr",  bus.daddr, 32'h4);
        check("g_snwb_dstore", bus.dstore, 32'hAB);
        tick; mem(1, 32'h0); snp(0, 0, 32'h0); settle;
        check("g_abort_dwen", 32'(bus.dWEN), 32'd0);
        tick; settle;
        check("g_idle_dren", 32'(bus.dREN), 32'd0);
        tick; mem(0, 32'h0); settle;
        check("g_refetch_dren",  32'(bus.dREN), 32'd1);
        check("g_refetch_daddr", bus.daddr, 32'h44);
        tick; mem(1, 32'h0); settle;
        check("g_done_dhit", 32'(bus.dhit), 32'd1);

        // Reset in the middle of a writeback of 0x44
        tick; req(0, 1, 32'h4, 32'hEF); settle;
        tick; settle;
        check("r_wb_dwen",   32'(bus.dWEN), 32'd1);
        check("r_wb_daddr",  bus.daddr, 32'h44);
        check("r_wb_dstore", bus.dstore, 32'hCD);
        #1 nRST = 1'b0;
        #1;
        check("r_dwen",   32'(bus.dWEN), 32'd0);
        check("r_daddr",  bus.daddr, 32'h0);
        check("r_dstore", bus.dstore, 32'h0);
        check("r_dhit",   32'(bus.dhit), 32'd0);
        tick; tick;
        nRST = 1'b1;
        req(1, 0, 32'h44, 32'h0); settle;
        check("r_miss44", 32'(bus.dhit), 32'd0);
        req(1, 0, 32'h4, 32'h0); settle;
        check("r_miss4", 32'(bus.dhit), 32'd0);
        req(0, 0, 32'h0, 32'h0);
        tick;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
